// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: datapath width, canonical NOP and fetch FSM states.
package riscv_pkg;

    localparam int unsigned     XLEN      = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register between instruction memory and decode, with flush.
module fetch_out_reg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_load,
    input  logic            i_ready,
    input  logic [XLEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc
);

    logic            r_valid;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc;

    // Flush drops the held word; a new load replaces it; otherwise ready drains it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_inst  <= INSTR_NOP;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: boot-loads the instruction memory from a serial loader,
// then fetches sequentially with branch redirect, halt and out-of-range detection.
module inst_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH    = 128,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter bit          LOAD_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic [31:0] imem_addr,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    input  logic [31:0] imem_rdata,
    input  logic        br_take,
    input  logic [31:0] br_target,
    input  logic        halt_req,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        fetch_err,
    output logic        busy_load
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [XLEN-1:0]  PC_LIMIT = XLEN'(DEPTH * 4);
    localparam logic [XLEN-1:0]  PC_INIT  = RESET_PC & ~32'h3;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    fetch_state_e     r_state;
    logic [XLEN-1:0]  r_pc;
    logic [PTR_W-1:0] r_ld_ptr;
    logic             r_fetch_err;

    logic w_loading;
    logic w_running;
    logic w_ld_accept;
    logic w_ld_done;
    logic w_if_valid;
    logic w_advance;
    logic w_pc_in_range;
    logic w_flush;
    logic w_capture;

    assign w_loading     = (r_state == ST_LOAD);
    assign w_running     = (r_state == ST_RUN);
    assign w_ld_accept   = w_loading && ld_valid;
    assign w_ld_done     = w_ld_accept && (ld_last || (r_ld_ptr == PTR_LAST));
    assign w_advance     = !w_if_valid || if_ready;
    assign w_pc_in_range = (r_pc < PC_LIMIT);
    // Branch outranks halt, which outranks a normal capture.
    assign w_flush       = w_running && br_take;
    assign w_capture     = w_running && !br_take && !halt_req && w_advance && w_pc_in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LOAD_EN ? ST_LOAD : ST_RUN;
            r_pc        <= PC_INIT;
            r_ld_ptr    <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_ld_done) begin
                        r_state  <= ST_RUN;
                        r_pc     <= PC_INIT;
                        r_ld_ptr <= '0;
                    end else if (w_ld_accept) begin
                        r_ld_ptr <= r_ld_ptr + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (br_take) begin
                        r_pc <= br_target & ~32'h3;
                    end else if (halt_req) begin
                        r_state <= ST_HALT;
                    end else if (w_advance) begin
                        if (w_pc_in_range) begin
                            r_pc <= r_pc + 32'd4;
                        end else begin
                            r_fetch_err <= 1'b1;
                            r_state     <= ST_HALT;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    fetch_out_reg u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_load  (w_capture),
        .i_ready (if_ready),
        .i_inst  (imem_rdata),
        .i_pc    (r_pc),
        .o_valid (w_if_valid),
        .o_inst  (if_inst),
        .o_pc    (if_pc)
    );

    assign if_valid   = w_if_valid;
    assign ld_ready   = w_loading;
    assign busy_load  = w_loading;
    assign imem_we    = w_ld_accept;
    assign imem_addr  = w_loading ? {{(XLEN - PTR_W - 2){1'b0}}, r_ld_ptr, 2'b00} : r_pc;
    assign imem_wdata = w_loading ? ld_data : '0;
    assign fetch_err  = r_fetch_err;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed and randomized bench for inst_fetch_ctrl with a word-stream reference model.
module tb_inst_fetch_ctrl;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic [31:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic        br_take;
    logic [31:0] br_target;
    logic        halt_req;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        fetch_err;
    logic        busy_load;

    logic [31:0] mem  [DEPTH];
    logic [31:0] gold [DEPTH];
    logic [31:0] prog [3];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    int unsigned acc;
    int unsigned nwords;
    logic        m_run;
    logic        m_valid;
    logic        m_err;
    logic [31:0] exp_pc;
    logic        br;
    logic        rdy;
    logic [31:0] tgt;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_we) mem[imem_addr[AW+1:2]] <= imem_wdata;
    end
    assign imem_rdata = mem[imem_addr[AW+1:2]];

    inst_fetch_ctrl #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0),
        .LOAD_EN  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .imem_addr  (imem_addr),
        .imem_we    (imem_we),
        .imem_wdata (imem_wdata),
        .imem_rdata (imem_rdata),
        .br_take    (br_take),
        .br_target  (br_target),
        .halt_req   (halt_req),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .fetch_err  (fetch_err),
        .busy_load  (busy_load)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h0010_8113;
        prog[2] = 32'h0000_006F;
        rst = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        br_take = 1'b0; br_target = '0; halt_req = 1'b0; if_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk1("rst_busy", busy_load, 1'b1);
        chk1("rst_ldrdy", ld_ready, 1'b1);
        chk1("rst_valid", if_valid, 1'b0);
        chk("rst_inst", if_inst, 32'h0000_0013);
        chk("rst_pc", if_pc, 32'h0);
        chk1("rst_err", fetch_err, 1'b0);
        chk1("rst_we", imem_we, 1'b0);

        // Full-depth load without ld_last: the DEPTH-th word ends LOAD
        rst = 1'b0;
        acc = 0;
        while (acc < DEPTH) begin
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = $urandom;
            ld_last  = 1'b0;
            #1;
            chk1("full_we", imem_we, ld_valid);
            if (ld_valid) begin
                chk("full_addr", imem_addr, 32'(acc * 4));
                gold[acc] = ld_data;
                acc++;
            end
            tick();
            if (acc < DEPTH) chk1("full_busy", busy_load, 1'b1);
        end
        ld_valid = 1'b0;
        #1;
        chk1("full_done", busy_load, 1'b0);
        chk1("full_ldrdy", ld_ready, 1'b0);
        chk1("full_we0", imem_we, 1'b0);
        chk("full_pc", imem_addr, 32'h0);

        // Halt with a word held: delivered on if_ready, then if_valid drops
        tick();
        chk1("halt_v0", if_valid, 1'b1);
        chk("halt_inst0", if_inst, gold[0]);
        halt_req = 1'b1;
        tick();
        chk1("halt_hold", if_valid, 1'b1);
        chk("halt_pc", if_pc, 32'h0);
        halt_req = 1'b0;
        tick();
        chk1("halt_hold2", if_valid, 1'b1);
        chk("halt_frz", imem_addr, 32'h4);
        if_ready = 1'b1;
        tick();
        chk1("halt_drain", if_valid, 1'b0);
        tick(); tick();
        chk1("halt_stay", if_valid, 1'b0);
        chk("halt_frz2", imem_addr, 32'h4);
        chk1("halt_noerr", fetch_err, 1'b0);

        // Three-word program load
        rst = 1'b1; if_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("t1_nop", if_inst, 32'h0000_0013);
        for (int unsigned i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = (i == 2);
            #1;
            chk1("t1_we", imem_we, 1'b1);
            chk("t1_addr", imem_addr, 32'(i * 4));
            chk("t1_wdata", imem_wdata, prog[i]);
            gold[i] = prog[i];
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        chk1("t1_busy", busy_load, 1'b0);
        chk1("t1_we0", imem_we, 1'b0);
        chk1("t1_v0", if_valid, 1'b0);

        // Sequential run, then a 3-cycle stall at pc 8
        if_ready = 1'b1;
        tick();
        chk1("t2_v", if_valid, 1'b1);
        chk("t2_pc0", if_pc, 32'h0);
        chk("t2_i0", if_inst, prog[0]);
        tick();
        chk("t2_pc4", if_pc, 32'h4);
        chk("t2_i4", if_inst, prog[1]);
        tick();
        chk("t2_pc8", if_pc, 32'h8);
        if_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            chk1("t3_v", if_valid, 1'b1);
            chk("t3_pc", if_pc, 32'h8);
            chk("t3_inst", if_inst, prog[2]);
        end
        if_ready = 1'b1;
        tick();
        chk("t3_pc12", if_pc, 32'hC);
        chk("t3_i12", if_inst, gold[3]);
        tick();
        chk("t3_pc16", if_pc, 32'h10);

        // Branch while stalled: flush, then target word
        if_ready = 1'b0; br_take = 1'b1; br_target = 32'h22;
        tick();
        chk1("t4_flush", if_valid, 1'b0);
        chk("t4_addr", imem_addr, 32'h20);
        br_take = 1'b0;
        tick();
        chk1("t4_v", if_valid, 1'b1);
        chk("t4_pc", if_pc, 32'h20);
        chk("t4_inst", if_inst, gold[8]);

        // Branch out of range: sticky error, halted until reset
        br_take = 1'b1; br_target = LIMIT;
        tick();
        chk1("t5_flush", if_valid, 1'b0);
        chk1("t5_noerr", fetch_err, 1'b0);
        br_take = 1'b0;
        tick();
        chk1("t5_err", fetch_err, 1'b1);
        chk1("t5_v", if_valid, 1'b0);
        for (int unsigned i = 0; i < 4; i++) begin
            if_ready  = $urandom_range(0, 1) != 0;
            halt_req  = $urandom_range(0, 1) != 0;
            br_take   = 1'b1;
            br_target = 32'h0;
            tick();
            chk1("t5_vstay", if_valid, 1'b0);
            chk1("t5_errstay", fetch_err, 1'b1);
            chk("t5_pcfrz", imem_addr, LIMIT);
        end
        br_take = 1'b0; halt_req = 1'b0;

        // Randomized rounds; round 0 aborts a load with reset after two words
        for (int unsigned r = 0; r < 4; r++) begin
            rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; br_take = 1'b0; if_ready = 1'b0;
            tick();
            rst = 1'b0;
            chk1("r_rstv", if_valid, 1'b0);
            chk1("r_rsterr", fetch_err, 1'b0);
            if (r == 0) begin
                for (int unsigned i = 0; i < 2; i++) begin
                    ld_valid = 1'b1;
                    ld_data  = $urandom;
                    #1;
                    chk("t6_addr", imem_addr, 32'(i * 4));
                    gold[i] = ld_data;
                    tick();
                end
                ld_valid = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk1("t6_busy", busy_load, 1'b1);
            end
            nwords = (r == 0) ? 5 : $urandom_range(1, 8);
            acc = 0;
            while (acc < nwords) begin
                ld_valid = ($urandom_range(0, 2) != 0);
                ld_data  = $urandom;
                ld_last  = ld_valid ? (acc == nwords - 1) : ($urandom_range(0, 1) != 0);
                #1;
                chk1("r_we", imem_we, ld_valid);
                if (ld_valid) begin
                    chk("r_addr", imem_addr, 32'(acc * 4));
                    gold[acc] = ld_data;
                    acc++;
                end
                tick();
            end
            ld_valid = 1'b0; ld_last = 1'b0;
            chk1("r_busy", busy_load, 1'b0);

            // Model tracks the word decode should see next, in program order
            m_run = 1'b1; m_valid = 1'b0; m_err = 1'b0; exp_pc = 32'h0;
            for (int unsigned c = 0; c < 150; c++) begin
                br = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 3) == 0)
                    tgt = LIMIT - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
                else
                    tgt = 32'($urandom_range(0, LIMIT - 1));
                rdy = br ? 1'b0 : ($urandom_range(0, 3) != 0);
                br_take = br; br_target = tgt; if_ready = rdy;
                if (m_run) begin
                    if (br) begin
                        exp_pc  = tgt & ~32'h3;
                        m_valid = 1'b0;
                    end else if (!m_valid || rdy) begin
                        if (m_valid) exp_pc = exp_pc + 32'd4;
                        if (exp_pc < LIMIT) begin
                            m_valid = 1'b1;
                        end else begin
                            m_valid = 1'b0;
                            m_run   = 1'b0;
                            m_err   = 1'b1;
                        end
                    end
                end else if (m_valid && rdy) begin
                    m_valid = 1'b0;
                end
                tick();
                chk1("rnd_valid", if_valid, m_valid);
                chk1("rnd_err", fetch_err, m_err);
                if (m_valid) begin
                    chk("rnd_pc", if_pc, exp_pc);
                    chk("rnd_inst", if_inst, gold[exp_pc[AW+1:2]]);
                end
            end
            br_take = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
